aes_job_dispatcher: RTL

- Host-facing initiator for the AES round-sequencing FSM (aes core controller).
- Accepts one job at a time over a valid/ready request channel and launches the core with a one-cycle start pulse.
- Holds mode/enc_dec/round count stable for the whole operation and monitors round_complete/done.
- Returns the result plus a status code over a valid/ready response channel; includes a timeout watchdog with a core abort.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_job_dispatcher.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared encodings for the AES job dispatcher: key-size modes, response status
// codes, dispatcher states and the mode-to-round-count mapping.
package aes_pkg;

   typedef enum logic [1:0] {
      MODE_AES128  = 2'b00,
      MODE_AES192  = 2'b01,
      MODE_AES256  = 2'b10,
      MODE_ILLEGAL = 2'b11
   } aes_mode_e;

   typedef enum logic [1:0] {
      RSP_OK             = 2'b00,
      RSP_ILLEGAL_MODE   = 2'b01,
      RSP_TIMEOUT        = 2'b10,
      RSP_ROUND_MISMATCH = 2'b11
   } rsp_status_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_LAUNCH = 2'b01,
      S_WAIT   = 2'b10,
      S_RESP   = 2'b11
   } disp_state_e;

   function automatic logic [3:0] mode_to_nr(input aes_mode_e mode);
      case (mode)
         MODE_AES192: return 4'd12;
         MODE_AES256: return 4'd14;
         default:     return 4'd10;
      endcase
   endfunction

endpackage

// File: rtl/aes_job_dispatcher.sv
// Single-job initiator for the AES core controller: launches the core, watches
// round/done pulses with a timeout watchdog, and returns result plus status.
module aes_job_dispatcher
   import aes_pkg::*;
#(
   parameter int DATA_W         = 128,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_mode,
   input  logic              req_enc_dec,
   output logic              core_start,
   output logic [1:0]        core_mode,
   output logic              core_enc_dec,
   output logic [3:0]        core_round_amount,
   output logic              core_abort,
   input  logic              core_round_complete,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status
);

   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   disp_state_e       state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              core_start_q, core_start_d;
   logic              core_abort_q, core_abort_d;
   aes_mode_e         mode_q, mode_d;
   logic              enc_dec_q, enc_dec_d;
   logic [3:0]        nr_q, nr_d;
   logic [4:0]        round_cnt_q, round_cnt_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   rsp_status_e       rsp_status_q, rsp_status_d;

   logic [4:0] rounds_seen;
   logic [4:0] rounds_expected;

   // Round count including a pulse in the current cycle; saturates so a runaway
   // core cannot wrap back onto the expected value.
   always_comb begin
      rounds_seen     = round_cnt_q;
      if (core_round_complete && (round_cnt_q != 5'd31)) begin
         rounds_seen = round_cnt_q + 5'd1;
      end
      rounds_expected = {1'b0, nr_q} + {4'b0000, enc_dec_q};
   end

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      core_start_d = 1'b0;
      core_abort_d = 1'b0;
      mode_d       = mode_q;
      enc_dec_d    = enc_dec_q;
      nr_d         = nr_q;
      round_cnt_d  = round_cnt_q;
      timer_d      = timer_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (aes_mode_e'(req_mode) == MODE_ILLEGAL) begin
                  rsp_status_d = RSP_ILLEGAL_MODE;
                  rsp_data_d   = '0;
                  rsp_valid_d  = 1'b1;
                  state_d      = S_RESP;
               end else begin
                  mode_d       = aes_mode_e'(req_mode);
                  enc_dec_d    = req_enc_dec;
                  nr_d         = mode_to_nr(aes_mode_e'(req_mode));
                  core_start_d = 1'b1;
                  state_d      = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            round_cnt_d = '0;
            timer_d     = '0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            round_cnt_d = rounds_seen;
            timer_d     = timer_q + 1'b1;
            if (core_done) begin
               rsp_data_d   = core_data;
               rsp_status_d = (rounds_seen == rounds_expected) ? RSP_OK : RSP_ROUND_MISMATCH;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else if (timer_q == TIMER_LAST) begin
               core_abort_d = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
               rsp_data_d   = '0;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         core_start_q <= 1'b0;
         core_abort_q <= 1'b0;
         mode_q       <= MODE_AES128;
         enc_dec_q    <= 1'b0;
         nr_q         <= 4'd10;
         round_cnt_q  <= '0;
         timer_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= RSP_OK;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         core_start_q <= core_start_d;
         core_abort_q <= core_abort_d;
         mode_q       <= mode_d;
         enc_dec_q    <= enc_dec_d;
         nr_q         <= nr_d;
         round_cnt_q  <= round_cnt_d;
         timer_q      <= timer_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign req_ready         = req_ready_q;
   assign core_start        = core_start_q;
   assign core_abort        = core_abort_q;
   assign core_mode         = mode_q;
   assign core_enc_dec      = enc_dec_q;
   assign core_round_amount = nr_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_data          = rsp_data_q;
   assign rsp_status        = rsp_status_q;

endmodule
